// File: rtl/frame_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_stream_reader_pkg
//  Description : Shared constants for the frame stream reader: FSM state
//                encoding, default image geometry, address width and a
//                counter-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package frame_stream_reader_pkg;

    // Frame-buffer address width; covers 320x240 = 76800 pixels.
    localparam int unsigned c_ADDR_W          = 17;

    // Default active image geometry.
    localparam int unsigned c_DEF_IMG_WIDTH   = 320;
    localparam int unsigned c_DEF_IMG_HEIGHT  = 240;

    // FSM state encoding.
    localparam int unsigned              c_STATE_W     = 3;
    localparam logic [c_STATE_W-1:0]     c_ST_IDLE     = 3'd0;
    localparam logic [c_STATE_W-1:0]     c_ST_VSYNC    = 3'd1;
    localparam logic [c_STATE_W-1:0]     c_ST_VPORCH   = 3'd2;
    localparam logic [c_STATE_W-1:0]     c_ST_ACTIVE   = 3'd3;
    localparam logic [c_STATE_W-1:0]     c_ST_BLANK    = 3'd4;

    // Width needed to count 0 .. max(a,b,c)-1 (at least one bit).
    function automatic int unsigned f_cnt_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_timing_counter.sv
`default_nettype none
// ============================================================================
//  Module      : stream_timing_counter
//  Description : Line-period counter, line counter and incrementing pixel
//                address counter with terminal-count flags. All state
//                advances only on enabled cycles.
//  Ports       : clk, rst_n        clock, async active-low reset
//                enable            clock enable
//                run               advance the line-period counter
//                clear             restart line-period and line counters
//                line_clear        restart the line counter (phase change)
//                addr_clear        restart the address counter
//                addr_inc          advance the address counter
//                line_end          last cycle of a line period
//                x_last            last active pixel of a line
//                line_cnt          line index within the current phase
//                addr              current pixel address
//  Revision    : 1.0  initial release
// ============================================================================
module stream_timing_counter
    import frame_stream_reader_pkg::*;
#(
    parameter int unsigned IMG_WIDTH = c_DEF_IMG_WIDTH,
    parameter int unsigned LINE_LEN  = c_DEF_IMG_WIDTH + 16,
    parameter int unsigned LINE_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                run,
    input  logic                clear,
    input  logic                line_clear,
    input  logic                addr_clear,
    input  logic                addr_inc,
    output logic                line_end,
    output logic                x_last,
    output logic [LINE_W-1:0]   line_cnt,
    output logic [c_ADDR_W-1:0] addr
);

    localparam int unsigned           c_LCNT_W    = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam logic [c_LCNT_W-1:0]   c_LCNT_LAST = c_LCNT_W'(LINE_LEN - 1);
    localparam logic [c_LCNT_W-1:0]   c_X_LAST    = c_LCNT_W'(IMG_WIDTH - 1);

    logic [c_LCNT_W-1:0] r_lcnt;
    logic [LINE_W-1:0]   r_line;
    logic [c_ADDR_W-1:0] r_addr;
    logic                w_line_end;

    // The pixel column equals the position inside the line period, since
    // every line period starts with its active pixels.
    assign w_line_end = (r_lcnt == c_LCNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lcnt <= '0;
        end else if (enable) begin
            if (clear) begin
                r_lcnt <= '0;
            end else if (run) begin
                r_lcnt <= w_line_end ? '0 : r_lcnt + 1'b1;
            end
        end
    end

    // A phase change clears the line count; otherwise it steps at every
    // line end, which also yields y+1 between active lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line <= '0;
        end else if (enable) begin
            if (clear || line_clear) begin
                r_line <= '0;
            end else if (run && w_line_end) begin
                r_line <= r_line + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (enable) begin
            if (addr_clear) begin
                r_addr <= '0;
            end else if (addr_inc) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign line_end = w_line_end;
    assign x_last   = (r_lcnt == c_X_LAST);
    assign line_cnt = r_line;
    assign addr     = r_addr;

endmodule
`default_nettype wire

// File: rtl/frame_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : frame_stream_reader
//  Description : Reads one frame (or back-to-back frames) out of a
//                synchronous frame buffer and streams it with vsync and
//                active-area timing aligned to the returned RAM data.
//  Ports       : clk, rst_n        clock, async active-low reset
//                enable            clock enable (freezes everything when 0)
//                start             one-cycle frame request, honoured in idle
//                continuous        run frames back-to-back (sampled at end)
//                fb_rd_en/fb_addr  frame-buffer read strobe and address
//                fb_data           RAM data, valid one enabled cycle later
//                pixel_out/addr    pixel and its address, aligned to fb_data
//                vsync/active_area timing, aligned to fb_data
//                busy              frame in progress
//                frame_done        one-cycle end-of-frame pulse
//  Revision    : 1.0  initial release
// ============================================================================
module frame_stream_reader
    import frame_stream_reader_pkg::*;
#(
    parameter int unsigned IMG_WIDTH    = c_DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT   = c_DEF_IMG_HEIGHT,
    parameter int unsigned H_BLANK      = 16,
    parameter int unsigned VSYNC_LINES  = 2,
    parameter int unsigned VPORCH_LINES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                start,
    input  logic                continuous,
    output logic                fb_rd_en,
    output logic [c_ADDR_W-1:0] fb_addr,
    input  logic [7:0]          fb_data,
    output logic [7:0]          pixel_out,
    output logic [c_ADDR_W-1:0] pixel_addr,
    output logic                vsync,
    output logic                active_area,
    output logic                busy,
    output logic                frame_done
);

    localparam int unsigned         c_LINE_LEN = IMG_WIDTH + H_BLANK;
    localparam int unsigned         c_LINE_W   = f_cnt_width(VSYNC_LINES, VPORCH_LINES, IMG_HEIGHT);
    localparam logic [c_LINE_W-1:0] c_VS_LAST  = c_LINE_W'(VSYNC_LINES - 1);
    localparam logic [c_LINE_W-1:0] c_VP_LAST  = c_LINE_W'(VPORCH_LINES - 1);
    localparam logic [c_LINE_W-1:0] c_Y_LAST   = c_LINE_W'(IMG_HEIGHT - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;
    logic                 w_cnt_clear;
    logic                 w_line_clear;
    logic                 w_addr_clear;
    logic                 w_frame_end;
    logic                 w_line_end;
    logic                 w_x_last;
    logic [c_LINE_W-1:0]  w_line_cnt;
    logic [c_ADDR_W-1:0]  w_addr;
    logic                 w_st_active;
    logic                 w_rd_en;

    logic                 r_vsync;
    logic                 r_active;
    logic [c_ADDR_W-1:0]  r_pixel_addr;
    logic                 r_frame_done;

    stream_timing_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .LINE_LEN  (c_LINE_LEN),
        .LINE_W    (c_LINE_W)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .run        (r_state != c_ST_IDLE),
        .clear      (w_cnt_clear),
        .line_clear (w_line_clear),
        .addr_clear (w_addr_clear),
        .addr_inc   (w_st_active),
        .line_end   (w_line_end),
        .x_last     (w_x_last),
        .line_cnt   (w_line_cnt),
        .addr       (w_addr)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else if (enable) begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and counter controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_clear  = 1'b0;
        w_line_clear = 1'b0;
        w_addr_clear = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = c_ST_VSYNC;
                    w_cnt_clear  = 1'b1;
                end
            end
            c_ST_VSYNC: begin
                if (w_line_end && (w_line_cnt == c_VS_LAST)) begin
                    w_state_next = c_ST_VPORCH;
                    w_line_clear = 1'b1;
                    w_addr_clear = 1'b1;
                end
            end
            c_ST_VPORCH: begin
                if (w_line_end && (w_line_cnt == c_VP_LAST)) begin
                    w_state_next = c_ST_ACTIVE;
                    w_line_clear = 1'b1;
                end
            end
            c_ST_ACTIVE: begin
                if (w_x_last) begin
                    w_state_next = c_ST_BLANK;
                end
            end
            c_ST_BLANK: begin
                if (w_line_end) begin
                    if (w_line_cnt == c_Y_LAST) begin
                        // continuous is only looked at here, so dropping it
                        // mid-frame lets the current frame finish.
                        w_frame_end  = 1'b1;
                        w_line_clear = 1'b1;
                        w_state_next = continuous ? c_ST_VSYNC : c_ST_IDLE;
                    end else begin
                        w_state_next = c_ST_ACTIVE;
                    end
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    assign w_st_active = (r_state == c_ST_ACTIVE);
    assign w_rd_en     = enable && w_st_active;

    // ------------------------------------------------------------------
    // Output alignment: one enabled cycle behind the read strobe so the
    // timing signals line up with the RAM data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync      <= 1'b0;
            r_active     <= 1'b0;
            r_pixel_addr <= '0;
            r_frame_done <= 1'b0;
        end else if (enable) begin
            r_vsync      <= (r_state == c_ST_VSYNC);
            r_active     <= w_st_active;
            r_pixel_addr <= w_st_active ? w_addr : '0;
            r_frame_done <= w_frame_end;
        end
    end

    assign fb_rd_en    = w_rd_en;
    assign fb_addr     = w_rd_en ? w_addr : '0;
    assign pixel_out   = r_active ? fb_data : 8'h00;
    assign pixel_addr  = r_pixel_addr;
    assign vsync       = r_vsync;
    assign active_area = r_active;
    assign busy        = (r_state != c_ST_IDLE);
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_frame_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_stream_reader
//  Description : Self-checking bench for frame_stream_reader with a small
//                4x3 image; directed scenarios plus randomized stimulus
//                against a frame-phase reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_stream_reader;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int HB   = 2;
    localparam int VS   = 1;
    localparam int VP   = 1;
    localparam int L    = W + HB;
    localparam int ACT0 = (VS + VP) * L;
    localparam int P    = (VS + VP + H) * L;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        enable     = 1'b0;
    logic        start      = 1'b0;
    logic        continuous = 1'b0;
    logic        fb_rd_en;
    logic [16:0] fb_addr;
    logic [7:0]  fb_data    = 8'h00;
    logic [7:0]  pixel_out;
    logic [16:0] pixel_addr;
    logic        vsync;
    logic        active_area;
    logic        busy;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    frame_stream_reader #(
        .IMG_WIDTH    (W),
        .IMG_HEIGHT   (H),
        .H_BLANK      (HB),
        .VSYNC_LINES  (VS),
        .VPORCH_LINES (VP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .start       (start),
        .continuous  (continuous),
        .fb_rd_en    (fb_rd_en),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .pixel_out   (pixel_out),
        .pixel_addr  (pixel_addr),
        .vsync       (vsync),
        .active_area (active_area),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    // Synchronous frame buffer whose content is address + 0x10.
    always @(posedge clk) begin
        if (fb_rd_en) fb_data <= 8'(fb_addr[7:0] + 8'h10);
    end

    // Frame phase helpers: phase 0 is the first vsync cycle of a frame.
    function automatic bit ph_active(input int ph);
        if (ph < ACT0 || ph >= P) return 1'b0;
        return ((ph - ACT0) % L) < W;
    endfunction

    function automatic int ph_addr(input int ph);
        int q;
        q = ph - ACT0;
        return (q / L) * W + (q % L);
    endfunction

    // Reference model: frame phase advanced per enabled cycle; aligned
    // outputs describe the phase of the previous enabled cycle.
    bit m_busy   = 1'b0;
    int m_ph     = 0;
    bit e_vsync  = 1'b0;
    bit e_active = 1'b0;
    bit e_done   = 1'b0;
    int e_paddr  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_ph     <= 0;
            e_vsync  <= 1'b0;
            e_active <= 1'b0;
            e_done   <= 1'b0;
            e_paddr  <= 0;
        end else if (enable) begin
            e_vsync  <= m_busy && (m_ph < VS * L);
            e_active <= m_busy && ph_active(m_ph);
            e_paddr  <= (m_busy && ph_active(m_ph)) ? ph_addr(m_ph) : 0;
            e_done   <= m_busy && (m_ph == P - 1);
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_ph   <= 0;
                end
            end else if (m_ph == P - 1) begin
                m_busy <= continuous;
                m_ph   <= 0;
            end else begin
                m_ph <= m_ph + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        enable     = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n      = 1'b1;
        enable     = 1'b1;
        start      = 1'b1;
        continuous = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_busy got=%0b exp=1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fb_rd_en, fb_addr, pixel_out, pixel_addr, vsync, active_area, busy, frame_done} !== 47'd0) begin
            failures++;
            $display("FAIL reset_async_outputs got=%h exp=0",
                     {fb_rd_en, fb_addr, pixel_out, pixel_addr, vsync, active_area, busy, frame_done});
        end
        start = 1'b1;
        tick();
        checks++;
        if ({busy, vsync, frame_done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_held got=%b exp=000", {busy, vsync, frame_done});
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_after busy got=%0b exp=0", busy);
        end
    endtask

    task automatic test_first_frame();
        int  rises;
        bit  prev;
        do_reset();
        enable = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        rises = 0;
        prev  = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            int r;
            bit ea;
            int ea_addr;
            r       = c - 14;
            ea      = (r >= 0) && ((r / L) < H) && ((r % L) < W);
            ea_addr = (r >= 0) ? (r / L) * W + (r % L) : 0;
            checks++;
            if (vsync !== (c >= 2 && c <= 7)) begin
                failures++;
                $display("FAIL frame_vsync c=%0d got=%0b exp=%0b", c, vsync, (c >= 2 && c <= 7));
            end
            checks++;
            if (active_area !== ea) begin
                failures++;
                $display("FAIL frame_active c=%0d got=%0b exp=%0b", c, active_area, ea);
            end
            if (ea) begin
                checks++;
                if (pixel_addr !== 17'(ea_addr) || pixel_out !== 8'(ea_addr + 16)) begin
                    failures++;
                    $display("FAIL frame_pixel c=%0d got addr=%0d pix=%h exp addr=%0d pix=%h",
                             c, pixel_addr, pixel_out, ea_addr, 8'(ea_addr + 16));
                end
            end else begin
                checks++;
                if (pixel_addr !== 17'd0 || pixel_out !== 8'h00) begin
                    failures++;
                    $display("FAIL frame_pixel_blank c=%0d got addr=%0d pix=%h exp 0", c, pixel_addr, pixel_out);
                end
            end
            checks++;
            if (frame_done !== (c == 31)) begin
                failures++;
                $display("FAIL frame_done c=%0d got=%0b exp=%0b", c, frame_done, (c == 31));
            end
            checks++;
            if (busy !== (c >= 1 && c <= 30)) begin
                failures++;
                $display("FAIL frame_busy c=%0d got=%0b exp=%0b", c, busy, (c >= 1 && c <= 30));
            end
            if (active_area && !prev) rises++;
            prev  = active_area;
            start = (c == 9);
            tick();
        end
        start = 1'b0;
        checks++;
        if (rises != H) begin
            failures++;
            $display("FAIL frame_active_runs got=%0d exp=%0d", rises, H);
        end
    endtask

    task automatic test_continuous();
        do_reset();
        enable     = 1'b1;
        continuous = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 66; c++) begin
            int r;
            int f;
            int ph;
            bit ev;
            bit ea;
            r  = c - 2;
            f  = (r >= 0) ? r / P : 0;
            ph = (r >= 0) ? r % P : 0;
            ev = (r >= 0) && (f < 2) && (ph < VS * L);
            ea = (r >= 0) && (f < 2) && ph_active(ph);
            checks++;
            if ({vsync, active_area} !== {ev, ea}) begin
                failures++;
                $display("FAIL cont_timing c=%0d got=%b exp=%b", c, {vsync, active_area}, {ev, ea});
            end
            if (ea) begin
                checks++;
                if (pixel_addr !== 17'(ph_addr(ph))) begin
                    failures++;
                    $display("FAIL cont_addr c=%0d got=%0d exp=%0d", c, pixel_addr, ph_addr(ph));
                end
            end
            checks++;
            if (frame_done !== (c == 31 || c == 61)) begin
                failures++;
                $display("FAIL cont_done c=%0d got=%0b exp=%0b", c, frame_done, (c == 31 || c == 61));
            end
            checks++;
            if (busy !== (c >= 1 && c <= 60)) begin
                failures++;
                $display("FAIL cont_busy c=%0d got=%0b exp=%0b", c, busy, (c >= 1 && c <= 60));
            end
            // Dropped mid second frame: that frame must still complete.
            if (c == 40) continuous = 1'b0;
            tick();
        end
    endtask

    task automatic test_enable_stall();
        bit found;
        int nxt;
        do_reset();
        enable = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (active_area === 1'b1 && pixel_addr === 17'd6) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL stall_wait timeout got=none exp=pixel_addr 6");
        end else begin
            enable = 1'b0;
            for (int k = 0; k < 5; k++) begin
                #1;
                checks++;
                if ({active_area, vsync, busy, frame_done, pixel_addr, pixel_out, fb_rd_en, fb_addr} !==
                    {1'b1, 1'b0, 1'b1, 1'b0, 17'd6, 8'h16, 1'b0, 17'd0}) begin
                    failures++;
                    $display("FAIL stall_frozen k=%0d got act=%0b addr=%0d pix=%h rd=%0b fa=%0d exp act=1 addr=6 pix=16 rd=0 fa=0",
                             k, active_area, pixel_addr, pixel_out, fb_rd_en, fb_addr);
                end
                tick();
            end
            enable = 1'b1;
            tick();
            checks++;
            if (active_area !== 1'b1 || pixel_addr !== 17'd7 || pixel_out !== 8'h17) begin
                failures++;
                $display("FAIL stall_resume got act=%0b addr=%0d pix=%h exp act=1 addr=7 pix=17",
                         active_area, pixel_addr, pixel_out);
            end
            nxt = 8;
            for (int k = 0; k < 20; k++) begin
                tick();
                if (active_area === 1'b1) begin
                    checks++;
                    if (pixel_addr !== 17'(nxt) || pixel_out !== 8'(nxt + 16)) begin
                        failures++;
                        $display("FAIL stall_sequence got addr=%0d pix=%h exp addr=%0d pix=%h",
                                 pixel_addr, pixel_out, nxt, 8'(nxt + 16));
                    end
                    nxt++;
                end
            end
            checks++;
            if (nxt != W * H) begin
                failures++;
                $display("FAIL stall_pixel_count got=%0d exp=%0d", nxt, W * H);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        do_reset();
        enable = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (active_area === 1'b1 && pixel_addr === 17'd9) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rstmid_wait timeout got=none exp=pixel_addr 9");
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fb_rd_en, fb_addr, pixel_out, pixel_addr, vsync, active_area, busy, frame_done} !== 47'd0) begin
            failures++;
            $display("FAIL rstmid_async got=%h exp=0",
                     {fb_rd_en, fb_addr, pixel_out, pixel_addr, vsync, active_area, busy, frame_done});
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            checks++;
            if ({busy, frame_done, vsync, active_area} !== 4'b0000) begin
                failures++;
                $display("FAIL rstmid_stays_idle k=%0d got=%b exp=0000", k, {busy, frame_done, vsync, active_area});
            end
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            checks++;
            if (vsync !== (c >= 2 && c <= 7)) begin
                failures++;
                $display("FAIL rstmid_new_vsync c=%0d got=%0b exp=%0b", c, vsync, (c >= 2 && c <= 7));
            end
            if (c == 14) begin
                checks++;
                if (active_area !== 1'b1 || pixel_addr !== 17'd0 || pixel_out !== 8'h10) begin
                    failures++;
                    $display("FAIL rstmid_new_first got act=%0b addr=%0d pix=%h exp act=1 addr=0 pix=10",
                             active_area, pixel_addr, pixel_out);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit         exp_rd;
        int         exp_fa;
        logic [7:0] exp_pix;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            start  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 59) == 0) continuous = ~continuous;
            #1;
            exp_rd  = enable && m_busy && ph_active(m_ph);
            exp_fa  = exp_rd ? ph_addr(m_ph) : 0;
            exp_pix = e_active ? 8'(e_paddr + 16) : 8'h00;
            checks++;
            if ({vsync, active_area, frame_done, busy} !== {e_vsync, e_active, e_done, m_busy}) begin
                failures++;
                $display("FAIL rand_flags i=%0d got=%b exp=%b", i,
                         {vsync, active_area, frame_done, busy}, {e_vsync, e_active, e_done, m_busy});
            end
            checks++;
            if (pixel_addr !== 17'(e_paddr)) begin
                failures++;
                $display("FAIL rand_pixel_addr i=%0d got=%0d exp=%0d", i, pixel_addr, e_paddr);
            end
            checks++;
            if (pixel_out !== exp_pix) begin
                failures++;
                $display("FAIL rand_pixel_out i=%0d got=%h exp=%h", i, pixel_out, exp_pix);
            end
            checks++;
            if ({fb_rd_en, fb_addr} !== {exp_rd, 17'(exp_fa)}) begin
                failures++;
                $display("FAIL rand_fb i=%0d got rd=%0b addr=%0d exp rd=%0b addr=%0d",
                         i, fb_rd_en, fb_addr, exp_rd, exp_fa);
            end
            tick();
        end
        start      = 1'b0;
        continuous = 1'b0;
    endtask

    initial begin
        tick();
        test_reset();
        test_first_frame();
        test_continuous();
        test_enable_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
